// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, stall/flush steering,
// and sticky timeout plus stall/flush statistics.
module hazard_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  IF_ID_RsAddr,
   input  logic [4:0]  IF_ID_RtAddr,
   input  logic        ID_EX_MemRd,
   input  logic [4:0]  ID_EX_RtAddr,
   input  logic        ID_Jump,
   input  logic        EX_BranchTaken,
   input  logic        MemReq,
   input  logic        MemReady,
   input  logic        ClrStat,
   output logic        PCWr,
   output logic [1:0]  IF_ID_HzCtrl,
   output logic [1:0]  ID_EX_HzCtrl,
   output logic [1:0]  EX_MEM_HzCtrl,
   output logic        MemTimeout,
   output logic [31:0] StallCnt,
   output logic [15:0] FlushCnt
);

   typedef enum logic {RUN, MEMWAIT} state_t;

   localparam logic [1:0] HZ_NORM  = 2'b00;
   localparam logic [1:0] HZ_FLUSH = 2'b01;
   localparam logic [1:0] HZ_STALL = 2'b10;

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic        tmo_q, tmo_d;
   logic [31:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;

   logic ms;
   logic load_use;
   logic flush_evt;

   assign ms = ~MemReady & (MemReq | (state_q == MEMWAIT));

   assign load_use = ID_EX_MemRd & (|ID_EX_RtAddr) &
                     ((ID_EX_RtAddr == IF_ID_RsAddr) |
                      (ID_EX_RtAddr == IF_ID_RtAddr));

   // Priority: memory stall, taken branch, load-use, jump.
   always_comb begin
      PCWr          = 1'b1;
      IF_ID_HzCtrl  = HZ_NORM;
      ID_EX_HzCtrl  = HZ_NORM;
      EX_MEM_HzCtrl = HZ_NORM;
      flush_evt     = 1'b0;
      if (rst) begin
         PCWr = 1'b0;
      end else if (ms) begin
         PCWr          = 1'b0;
         IF_ID_HzCtrl  = HZ_STALL;
         ID_EX_HzCtrl  = HZ_STALL;
         EX_MEM_HzCtrl = HZ_STALL;
      end else if (EX_BranchTaken) begin
         IF_ID_HzCtrl = HZ_FLUSH;
         ID_EX_HzCtrl = HZ_FLUSH;
         flush_evt    = 1'b1;
      end else if (load_use) begin
         PCWr         = 1'b0;
         IF_ID_HzCtrl = HZ_STALL;
         ID_EX_HzCtrl = HZ_FLUSH;
      end else if (ID_Jump) begin
         IF_ID_HzCtrl = HZ_FLUSH;
         flush_evt    = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      if (state_q == RUN) begin
         if (MemReq && !MemReady) begin
            state_d = MEMWAIT;
            wait_d  = 8'd0;
         end
      end else begin
         if (MemReady) state_d = RUN;
         if (wait_q != 8'hFF) wait_d = wait_q + 8'd1;
      end
   end

   always_comb begin
      tmo_d   = tmo_q;
      stall_d = stall_q;
      flush_d = flush_q;
      if (ClrStat) begin
         tmo_d   = 1'b0;
         stall_d = 32'd0;
         flush_d = 16'd0;
      end else begin
         if (state_q == MEMWAIT && wait_q == 8'd254)
            tmo_d = 1'b1;
         if (!PCWr && stall_q != 32'hFFFF_FFFF)
            stall_d = stall_q + 32'd1;
         if (flush_evt && flush_q != 16'hFFFF)
            flush_d = flush_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         wait_q  <= 8'd0;
         tmo_q   <= 1'b0;
         stall_q <= 32'd0;
         flush_q <= 16'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         tmo_q   <= tmo_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign MemTimeout = tmo_q;
   assign StallCnt   = stall_q;
   assign FlushCnt   = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  IF_ID_RsAddr, IF_ID_RtAddr, ID_EX_RtAddr;
   logic        ID_EX_MemRd, ID_Jump, EX_BranchTaken;
   logic        MemReq, MemReady, ClrStat;
   logic        PCWr, MemTimeout;
   logic [1:0]  IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl;
   logic [31:0] StallCnt;
   logic [15:0] FlushCnt;

   int errors = 0;
   int checks = 0;

   // Model state
   bit          m_wait;
   int          m_wcnt;
   bit          m_to;
   logic [31:0] m_stall;
   logic [15:0] m_flush;

   wire [6:0] ctrl = {PCWr, IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl};

   hazard_ctrl dut (
      .clk(clk), .rst(rst),
      .IF_ID_RsAddr(IF_ID_RsAddr), .IF_ID_RtAddr(IF_ID_RtAddr),
      .ID_EX_MemRd(ID_EX_MemRd), .ID_EX_RtAddr(ID_EX_RtAddr),
      .ID_Jump(ID_Jump), .EX_BranchTaken(EX_BranchTaken),
      .MemReq(MemReq), .MemReady(MemReady), .ClrStat(ClrStat),
      .PCWr(PCWr), .IF_ID_HzCtrl(IF_ID_HzCtrl),
      .ID_EX_HzCtrl(ID_EX_HzCtrl), .EX_MEM_HzCtrl(EX_MEM_HzCtrl),
      .MemTimeout(MemTimeout), .StallCnt(StallCnt),
      .FlushCnt(FlushCnt)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] exp_ctrl();
      bit ms, lu;
      ms = !MemReady && (MemReq || m_wait);
      lu = ID_EX_MemRd && ID_EX_RtAddr != 0 &&
           (ID_EX_RtAddr == IF_ID_RsAddr ||
            ID_EX_RtAddr == IF_ID_RtAddr);
      if (rst)                 return 7'b0_00_00_00;
      else if (ms)             return 7'b0_10_10_10;
      else if (EX_BranchTaken) return 7'b1_01_01_00;
      else if (lu)             return 7'b0_10_01_00;
      else if (ID_Jump)        return 7'b1_01_00_00;
      else                     return 7'b1_00_00_00;
   endfunction

   task automatic model_reset();
      m_wait = 0; m_wcnt = 0; m_to = 0;
      m_stall = 0; m_flush = 0;
   endtask

   task automatic model_update();
      logic [6:0] e;
      if (rst) begin
         model_reset();
         return;
      end
      e = exp_ctrl();
      if (ClrStat) begin
         m_stall = 0; m_flush = 0; m_to = 0;
      end else begin
         if (!e[6] && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (e[6] && e[5:4] == 2'b01 && m_flush != 16'hFFFF)
            m_flush++;
         if (m_wait && m_wcnt == 254) m_to = 1;
      end
      if (m_wait) begin
         if (m_wcnt < 255) m_wcnt++;
         if (MemReady) m_wait = 0;
      end else if (MemReq && !MemReady) begin
         m_wait = 1;
         m_wcnt = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle();
      IF_ID_RsAddr = 0; IF_ID_RtAddr = 0; ID_EX_RtAddr = 0;
      ID_EX_MemRd = 0; ID_Jump = 0; EX_BranchTaken = 0;
      MemReq = 0; MemReady = 0; ClrStat = 0;
   endtask

   task automatic test_reset();
      idle();
      MemReq = 1;
      rst = 1;
      model_reset();
      #1;
      checks++;
      if (ctrl !== 7'b0_00_00_00) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=%b", ctrl, 7'b0);
      end
      tick();
      checks++;
      if (StallCnt !== 0 || FlushCnt !== 0 || MemTimeout !== 0) begin
         errors++;
         $display("FAIL reset_stats got=%0d/%0d/%b exp=0/0/0",
                  StallCnt, FlushCnt, MemTimeout);
      end
      rst = 0;
      MemReq = 0;
      #1;
      checks++;
      if (ctrl !== 7'b1_00_00_00) begin
         errors++;
         $display("FAIL reset_release got=%b exp=%b",
                  ctrl, 7'b1_00_00_00);
      end
      tick();
   endtask

   task automatic test_load_use();
      logic [31:0] s;
      idle();
      ID_EX_MemRd = 1; ID_EX_RtAddr = 5;
      IF_ID_RsAddr = 5; IF_ID_RtAddr = 7;
      #1;
      checks++;
      if (ctrl !== 7'b0_10_01_00) begin
         errors++;
         $display("FAIL load_use_rs got=%b exp=%b",
                  ctrl, 7'b0_10_01_00);
      end
      s = m_stall;
      tick();
      checks++;
      if (StallCnt !== s + 1) begin
         errors++;
         $display("FAIL load_use_cnt got=%0d exp=%0d",
                  StallCnt, s + 1);
      end
      IF_ID_RsAddr = 2; IF_ID_RtAddr = 5;
      #1;
      checks++;
      if (ctrl !== 7'b0_10_01_00) begin
         errors++;
         $display("FAIL load_use_rt got=%b exp=%b",
                  ctrl, 7'b0_10_01_00);
      end
      tick();
      ID_EX_RtAddr = 0; IF_ID_RsAddr = 0; IF_ID_RtAddr = 0;
      s = m_stall;
      #1;
      checks++;
      if (ctrl !== 7'b1_00_00_00) begin
         errors++;
         $display("FAIL load_r0 got=%b exp=%b",
                  ctrl, 7'b1_00_00_00);
      end
      tick();
      checks++;
      if (StallCnt !== s) begin
         errors++;
         $display("FAIL load_r0_cnt got=%0d exp=%0d", StallCnt, s);
      end
   endtask

   task automatic test_branch_jump();
      logic [15:0] f;
      idle();
      EX_BranchTaken = 1; ID_Jump = 1;
      f = m_flush;
      #1;
      checks++;
      if (ctrl !== 7'b1_01_01_00) begin
         errors++;
         $display("FAIL br_jmp got=%b exp=%b", ctrl, 7'b1_01_01_00);
      end
      tick();
      checks++;
      if (FlushCnt !== f + 1) begin
         errors++;
         $display("FAIL br_jmp_cnt got=%0d exp=%0d",
                  FlushCnt, f + 1);
      end
      EX_BranchTaken = 0;
      #1;
      checks++;
      if (ctrl !== 7'b1_01_00_00) begin
         errors++;
         $display("FAIL jump got=%b exp=%b", ctrl, 7'b1_01_00_00);
      end
      tick();
      ID_EX_MemRd = 1; ID_EX_RtAddr = 9; IF_ID_RsAddr = 9;
      f = m_flush;
      #1;
      checks++;
      if (ctrl !== 7'b0_10_01_00) begin
         errors++;
         $display("FAIL lu_over_jump got=%b exp=%b",
                  ctrl, 7'b0_10_01_00);
      end
      tick();
      checks++;
      if (FlushCnt !== f) begin
         errors++;
         $display("FAIL lu_over_jump_cnt got=%0d exp=%0d",
                  FlushCnt, f);
      end
   endtask

   task automatic test_memwait();
      idle();
      ClrStat = 1;
      tick();
      ClrStat = 0;
      MemReq = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ctrl !== 7'b0_10_10_10) begin
            errors++;
            $display("FAIL memwait_stall[%0d] got=%b exp=%b",
                     i, ctrl, 7'b0_10_10_10);
         end
         tick();
      end
      MemReady = 1;
      #1;
      checks++;
      if (ctrl !== 7'b1_00_00_00) begin
         errors++;
         $display("FAIL memwait_done got=%b exp=%b",
                  ctrl, 7'b1_00_00_00);
      end
      tick();
      checks++;
      if (StallCnt !== 32'd3) begin
         errors++;
         $display("FAIL memwait_cnt got=%0d exp=3", StallCnt);
      end
      idle();
      #1;
      checks++;
      if (ctrl !== 7'b1_00_00_00) begin
         errors++;
         $display("FAIL memwait_run got=%b exp=%b",
                  ctrl, 7'b1_00_00_00);
      end
      tick();
   endtask

   task automatic test_branch_during_wait();
      logic [15:0] f;
      idle();
      EX_BranchTaken = 1;
      MemReq = 1;
      f = m_flush;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (ctrl !== 7'b0_10_10_10) begin
            errors++;
            $display("FAIL br_wait[%0d] got=%b exp=%b",
                     i, ctrl, 7'b0_10_10_10);
         end
         tick();
         MemReq = 0;
      end
      checks++;
      if (FlushCnt !== f) begin
         errors++;
         $display("FAIL br_wait_cnt got=%0d exp=%0d", FlushCnt, f);
      end
      MemReady = 1;
      #1;
      checks++;
      if (ctrl !== 7'b1_01_01_00) begin
         errors++;
         $display("FAIL br_after_wait got=%b exp=%b",
                  ctrl, 7'b1_01_01_00);
      end
      tick();
      checks++;
      if (FlushCnt !== f + 1) begin
         errors++;
         $display("FAIL br_after_cnt got=%0d exp=%0d",
                  FlushCnt, f + 1);
      end
      idle();
      tick();
   endtask

   task automatic test_timeout();
      idle();
      MemReq = 1;
      for (int i = 1; i <= 300; i++) begin
         #1;
         checks++;
         if (ctrl !== 7'b0_10_10_10) begin
            errors++;
            $display("FAIL tmo_stall[%0d] got=%b", i, ctrl);
         end
         tick();
         checks++;
         if (MemTimeout !== (i >= 256) || MemTimeout !== m_to) begin
            errors++;
            $display("FAIL tmo_flag[%0d] got=%b exp=%b",
                     i, MemTimeout, i >= 256);
         end
      end
      ClrStat = 1;
      tick();
      ClrStat = 0;
      checks++;
      if (MemTimeout !== 0 || StallCnt !== 0) begin
         errors++;
         $display("FAIL tmo_clear got=%b/%0d exp=0/0",
                  MemTimeout, StallCnt);
      end
      MemReady = 1;
      tick();
      idle();
      #1;
      checks++;
      if (ctrl !== 7'b1_00_00_00) begin
         errors++;
         $display("FAIL tmo_exit got=%b exp=%b",
                  ctrl, 7'b1_00_00_00);
      end
      tick();
   endtask

   task automatic test_rst_midwait();
      idle();
      MemReq = 1;
      tick();
      tick();
      #2;
      rst = 1;
      model_reset();
      #1;
      checks++;
      if (ctrl !== 7'b0 || StallCnt !== 0 || MemTimeout !== 0) begin
         errors++;
         $display("FAIL rst_mid got=%b/%0d/%b exp=0/0/0",
                  ctrl, StallCnt, MemTimeout);
      end
      tick();
      rst = 0;
      MemReq = 0;
      #1;
      checks++;
      if (ctrl !== 7'b1_00_00_00) begin
         errors++;
         $display("FAIL rst_mid_release got=%b exp=%b",
                  ctrl, 7'b1_00_00_00);
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(199) == 0);
         if (rst) model_reset();
         IF_ID_RsAddr   = 5'($urandom_range(3));
         IF_ID_RtAddr   = 5'($urandom_range(3));
         ID_EX_RtAddr   = 5'($urandom_range(3));
         ID_EX_MemRd    = $urandom_range(1);
         ID_Jump        = ($urandom_range(3) == 0);
         EX_BranchTaken = ($urandom_range(3) == 0);
         MemReq         = ($urandom_range(2) == 0);
         MemReady       = ($urandom_range(2) == 0);
         ClrStat        = ($urandom_range(49) == 0);
         #1;
         checks++;
         if (ctrl !== exp_ctrl()) begin
            errors++;
            $display("FAIL rnd_ctrl[%0d] got=%b exp=%b",
                     i, ctrl, exp_ctrl());
         end
         tick();
         checks++;
         if (StallCnt !== m_stall || FlushCnt !== m_flush ||
             MemTimeout !== m_to) begin
            errors++;
            $display("FAIL rnd_stats[%0d] got=%0d/%0d/%b exp=%0d/%0d/%b",
                     i, StallCnt, FlushCnt, MemTimeout,
                     m_stall, m_flush, m_to);
         end
      end
      rst = 0;
      idle();
   endtask

   initial begin
      rst = 1;
      idle();
      model_reset();
      @(negedge clk);
      test_reset();
      test_load_use();
      test_branch_jump();
      test_memwait();
      test_branch_during_wait();
      test_timeout();
      test_rst_midwait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset; asynchronous, active-high.
REQ-003 IF_ID_RsAddr, IF_ID_RtAddr  in  5 each  source register addresses of the instruction in ID.
REQ-004 ID_EX_MemRd  in  1  instruction in EX is a load.
REQ-005 ID_EX_RtAddr  in  5  load destination address in EX.
REQ-006 ID_Jump  in  1  j/jal/jr resolved in ID; redirect this cycle.
REQ-007 EX_BranchTaken  in  1  conditional branch resolved taken in EX.
REQ-008 MemReq  in  1  data-memory access active in MEM.
REQ-009 MemReady  in  1  data memory completes the access this cycle.
REQ-010 ClrStat  in  1  synchronous clear of counters and timeout flag.
REQ-011 PCWr  out  1  PC update enable.
REQ-012 IF_ID_HzCtrl, ID_EX_HzCtrl, EX_MEM_HzCtrl  out  2 each  pipeline-register control: 00 normal, 01 flush, 10 stall; 11 never driven.
REQ-013 MemTimeout  out  1  sticky: memory wait exceeded limit.
REQ-014 StallCnt  out  32  cycles with PCWr=0 since reset/clear.
REQ-015 FlushCnt  out  16  flush events since reset/clear.

Function
REQ-016 Two-state FSM: RUN, MEMWAIT; reset state RUN.
REQ-017 RUN->MEMWAIT on an edge where MemReq=1 and MemReady=0; MEMWAIT->RUN on an edge where MemReady=1; MEMWAIT persists otherwise, including when MemReq drops.
REQ-018 Stall outputs are combinational from state and inputs, so they take effect at the same edge; no added latency.
REQ-019 Memory stall condition MS = (MemReq & ~MemReady) | (MEMWAIT & ~MemReady).
REQ-020 MS=1 (highest priority): PCWr=0, IF_ID=10, ID_EX=10, EX_MEM=10; branch, jump and load-use are ignored that cycle.
REQ-021 Else EX_BranchTaken=1: PCWr=1, IF_ID=01, ID_EX=01, EX_MEM=00.
REQ-022 Else load-use: ID_EX_MemRd=1, ID_EX_RtAddr!=0, and ID_EX_RtAddr equals IF_ID_RsAddr or IF_ID_RtAddr.
REQ-023 Load-use response: PCWr=0, IF_ID=10, ID_EX=01, EX_MEM=00.
REQ-024 Else ID_Jump=1: PCWr=1, IF_ID=01, ID_EX=00, EX_MEM=00.
REQ-025 Else: PCWr=1, all HzCtrl=00.
REQ-026 A branch held in EX during MS is serviced in the first cycle after MS deasserts.
REQ-027 WaitCnt (8 bit, internal): cleared on entering MEMWAIT; increments each MEMWAIT cycle; saturates at 255.
REQ-028 MemTimeout sets on the edge WaitCnt reaches 255; stays set until rst or ClrStat; FSM keeps waiting.
REQ-029 StallCnt increments each edge with PCWr=0; saturates at 32'hFFFFFFFF.
REQ-030 FlushCnt increments each edge on which the branch rule (REQ-021) or jump rule (REQ-024) is applied; saturates at 16'hFFFF.
REQ-031 ClrStat=1 zeroes StallCnt, FlushCnt and MemTimeout at the edge; clear wins over a simultaneous increment or set; FSM and WaitCnt are unaffected.

Reset
REQ-032 While rst=1: state RUN, WaitCnt=0, StallCnt=0, FlushCnt=0, MemTimeout=0, PCWr=0, all HzCtrl=00.
REQ-033 rst asserted mid-MEMWAIT aborts the wait immediately; after release the FSM is in RUN and MemReq is re-evaluated.

Verification
REQ-034 Load x5 in EX (MemRd=1, Rt=5), ID Rs=5 -> PCWr=0, IF_ID=10, ID_EX=01; StallCnt +1. Same with Rt=0 -> no stall.
REQ-035 EX_BranchTaken=1 and ID_Jump=1 together -> PCWr=1, IF_ID=01, ID_EX=01; FlushCnt +1 (not +2).
REQ-036 MemReq=1, MemReady=0 for 3 cycles, then MemReady=1 -> 3 cycles of all 10 with PCWr=0, then RUN; StallCnt=3.
REQ-037 Branch taken during a 2-cycle memory wait -> no flush during the wait; flush in the cycle after MemReady.
REQ-038 MemReady held 0 for 300 cycles -> MemTimeout=1 after 255 wait cycles, stall continues; ClrStat -> MemTimeout=0, StallCnt=0.
REQ-039 rst pulse during MEMWAIT -> outputs at reset values; after release with MemReq=0, PCWr=1, all HzCtrl=00.
